// File: rtl/ak16_pkg.sv
// Shared AK16 front-end types and widths used by the fetch sequencer and its queue.
package ak16_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} pairs between imem responses and decode.
// Flush wins over a same-cycle push; push and pop together while full is legal.
module fetch_queue
    import ak16_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [PC_W-1:0]          push_pc,
    input  logic [INSTR_W-1:0]       push_instr,
    input  logic                     pop,
    input  logic                     flush,
    output logic [PC_W-1:0]          head_pc,
    output logic [INSTR_W-1:0]       head_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (!push && pop)
                count <= count - CW'(1);
        end
    end

    // Storage carries no reset; occupancy is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives the PC register and imem, queues responses, hands words to decode.
// Optional FETCH_PERF_EN adds a saturating perf_stall_cnt output.
module fetch_ctrl
    import ak16_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter logic [PC_W-1:0] PC_STEP  = 16'd1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    pc_cur,
    output logic [PC_W-1:0]    next_pc,
    output logic               pc_en,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
`ifdef FETCH_PERF_EN
    output logic [15:0]        perf_stall_cnt,
`endif
    input  logic               if_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t      state;
    fetch_state_t      state_d;
    logic              inflight;
    logic [PC_W-1:0]   tag_pc;
    logic [CW-1:0]     count;
    logic [PC_W-1:0]   head_pc;
    logic [INSTR_W-1:0] head_instr;
    logic              pop;
    logic              push;
    logic              flush;
    logic              room;
    logic              req_d;
    logic              pc_en_d;
    logic [PC_W-1:0]   next_pc_d;
    int                occ;

    assign if_valid = (count != '0);
    assign pop      = if_valid && if_ready;
    assign flush    = redirect && (state != BOOT);
    // A response landing in a redirect cycle belongs to the abandoned path.
    assign push     = inflight && !flush;

    always_comb begin
        occ       = int'(count) + int'(inflight) - int'(pop);
        room      = (occ < DEPTH);
        state_d   = state;
        req_d     = 1'b0;
        pc_en_d   = 1'b0;
        next_pc_d = '0;
        case (state)
            BOOT: begin
                pc_en_d   = 1'b1;
                next_pc_d = RESET_PC;
                state_d   = RUN;
            end
            default: begin
                if (redirect) begin
                    pc_en_d   = 1'b1;
                    next_pc_d = redirect_pc;
                    state_d   = RUN;
                end else if (room) begin
                    req_d     = 1'b1;
                    pc_en_d   = 1'b1;
                    next_pc_d = pc_cur + PC_STEP;
                    state_d   = RUN;
                end else begin
                    state_d   = STALL;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BOOT;
            inflight <= 1'b0;
        end else begin
            state    <= state_d;
            inflight <= req_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_d)
            tag_pc <= pc_cur;
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_pc    (tag_pc),
        .push_instr (imem_rdata),
        .pop        (pop),
        .flush      (flush),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .count      (count)
    );

    // BOOT drives the PC register, so outputs are forced quiet while rst is held.
    assign pc_en     = pc_en_d && !rst;
    assign next_pc   = rst ? '0 : next_pc_d;
    assign imem_req  = req_d && !rst;
    assign imem_addr = rst ? '0 : pc_cur;
    assign if_instr  = if_valid ? head_instr : '0;
    assign if_pc     = if_valid ? head_pc : '0;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_stall_cnt <= '0;
        else if (((if_valid && !if_ready) || state == STALL) && perf_stall_cnt != 16'hFFFF)
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
`endif

endmodule
